// File: rtl/clock_supervisor.sv
// MMCM reset/lock supervisor: sequences the MMCM through reset, lock wait and
// lock qualification, then releases a filtered system reset to downstream logic.
// state  | meaning
// PLLRST | MMCM RST held high for RST_PULSE_CYCLES
// WAIT   | waiting for synchronised LOCKED, bounded by LOCK_TIMEOUT
// HOLD   | LOCKED must stay high HOLD_CYCLES before release
// RUN    | system running; LOSS_FILTER consecutive unlocked cycles = loss
module clock_supervisor #(
    parameter int RST_PULSE_CYCLES = 16,
    parameter int LOCK_TIMEOUT     = 65536,
    parameter int HOLD_CYCLES      = 1024,
    parameter int LOSS_FILTER      = 4
) (
    input  logic       CLK_IN1,
    input  logic       reset,
    input  logic       locked,
    input  logic       force_relock,
    input  logic       clr_lost,
    output logic       mmcm_rst,
    output logic       sys_reset,
    output logic       ready,
    output logic       lock_lost,
    output logic [7:0] retry_count
);

    localparam int MAX_AB = (RST_PULSE_CYCLES > LOCK_TIMEOUT) ? RST_PULSE_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CD = (HOLD_CYCLES > LOSS_FILTER) ? HOLD_CYCLES : LOSS_FILTER;
    localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW     = $clog2(MAX_P + 1);

    typedef enum logic [1:0] {
        S_PLLRST = 2'd0,
        S_WAIT   = 2'd1,
        S_HOLD   = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            r_lock_meta;
    logic            r_locked_s;
    logic            w_restart;
    logic            w_lost_set;
    logic            w_mmcm_rst_nxt;
    logic            w_sys_reset_nxt;
    logic            w_ready_nxt;
    logic            w_lock_lost_nxt;
    logic [7:0]      w_retry_nxt;

    // State, counter, synchroniser and registered outputs
    always_ff @(posedge CLK_IN1 or posedge reset) begin
        if (reset) begin
            r_state     <= S_PLLRST;
            r_cnt       <= '0;
            r_lock_meta <= 1'b0;
            r_locked_s  <= 1'b0;
            mmcm_rst    <= 1'b1;
            sys_reset   <= 1'b1;
            ready       <= 1'b0;
            lock_lost   <= 1'b0;
            retry_count <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_lock_meta <= locked;
            r_locked_s  <= r_lock_meta;
            mmcm_rst    <= w_mmcm_rst_nxt;
            sys_reset   <= w_sys_reset_nxt;
            ready       <= w_ready_nxt;
            lock_lost   <= w_lock_lost_nxt;
            retry_count <= w_retry_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CW'(1);
        w_restart   = 1'b0;
        w_lost_set  = 1'b0;
        if (force_relock) begin
            w_state_nxt = S_PLLRST;
            w_cnt_nxt   = '0;
            w_restart   = 1'b1;
        end else begin
            unique case (r_state)
                S_PLLRST: begin
                    if (r_cnt == CW'(RST_PULSE_CYCLES - 1)) begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = '0;
                    end
                end
                S_WAIT: begin
                    if (r_locked_s) begin
                        w_state_nxt = S_HOLD;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == CW'(LOCK_TIMEOUT - 1)) begin
                        w_state_nxt = S_PLLRST;
                        w_cnt_nxt   = '0;
                        w_restart   = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!r_locked_s) begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == CW'(HOLD_CYCLES - 1)) begin
                        w_state_nxt = S_RUN;
                        w_cnt_nxt   = '0;
                    end
                end
                S_RUN: begin
                    // cnt tracks consecutive unlocked cycles only
                    if (r_locked_s) begin
                        w_cnt_nxt = '0;
                    end else if (r_cnt == CW'(LOSS_FILTER - 1)) begin
                        w_state_nxt = S_PLLRST;
                        w_cnt_nxt   = '0;
                        w_restart   = 1'b1;
                        w_lost_set  = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_PLLRST;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the transition edge
    always_comb begin
        w_mmcm_rst_nxt  = (w_state_nxt == S_PLLRST);
        w_sys_reset_nxt = (w_state_nxt != S_RUN);
        w_ready_nxt     = (w_state_nxt == S_RUN);
        w_lock_lost_nxt = lock_lost;
        if (w_lost_set) begin
            w_lock_lost_nxt = 1'b1;
        end else if (clr_lost) begin
            w_lock_lost_nxt = 1'b0;
        end
        w_retry_nxt = retry_count;
        if (w_restart && (retry_count != 8'hFF)) begin
            w_retry_nxt = retry_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_clock_supervisor.sv
// Directed bench for clock_supervisor: a timing model tracks pulse/wait/hold
// remaining cycles and every output is compared against it on each negedge.
module tb_clock_supervisor;
    localparam int P  = 4;
    localparam int LT = 32;
    localparam int H  = 8;
    localparam int LF = 3;

    logic       CLK_IN1 = 1'b0;
    logic       reset = 1'b0;
    logic       locked = 1'b0;
    logic       force_relock = 1'b0;
    logic       clr_lost = 1'b0;
    logic       mmcm_rst, sys_reset, ready, lock_lost;
    logic [7:0] retry_count;

    int n_vec = 0;
    int n_bad = 0;

    always #5 CLK_IN1 = ~CLK_IN1;

    clock_supervisor #(
        .RST_PULSE_CYCLES(P),
        .LOCK_TIMEOUT(LT),
        .HOLD_CYCLES(H),
        .LOSS_FILTER(LF)
    ) dut (
        .CLK_IN1(CLK_IN1),
        .reset(reset),
        .locked(locked),
        .force_relock(force_relock),
        .clr_lost(clr_lost),
        .mmcm_rst(mmcm_rst),
        .sys_reset(sys_reset),
        .ready(ready),
        .lock_lost(lock_lost),
        .retry_count(retry_count)
    );

    // Model: remaining pulse cycles, low cycles spent waiting, consecutive
    // highs seen toward qualification, consecutive lows while running.
    bit [1:0] m_pipe;
    int       m_pulse, m_wait, m_hold, m_low, m_retry;
    bit       m_run, m_lost;
    logic     mo_mmcm, mo_sys, mo_ready, mo_lost;
    logic [7:0] mo_retry;

    assign mo_mmcm  = (m_pulse > 0);
    assign mo_sys   = !m_run;
    assign mo_ready = m_run;
    assign mo_lost  = m_lost;
    assign mo_retry = 8'(m_retry);

    always @(posedge CLK_IN1 or posedge reset) begin
        if (reset) begin
            m_pipe = 2'b00;
            m_pulse = P; m_wait = 0; m_hold = 0; m_low = 0; m_run = 0;
            m_lost = 0; m_retry = 0;
        end else begin
            bit ls, set, restart;
            ls = m_pipe[1];
            m_pipe = {m_pipe[0], locked};
            set = 0;
            restart = 0;
            if (force_relock) restart = 1;
            else if (m_pulse > 0) m_pulse--;
            else if (m_run) begin
                if (ls) m_low = 0;
                else begin
                    m_low++;
                    if (m_low == LF) begin restart = 1; set = 1; end
                end
            end else if (m_hold > 0) begin
                if (!ls) begin m_hold = 0; m_wait = 0; end
                else begin
                    m_hold++;
                    if (m_hold == H + 1) begin m_run = 1; m_low = 0; end
                end
            end else begin
                if (ls) m_hold = 1;
                else begin
                    m_wait++;
                    if (m_wait == LT) restart = 1;
                end
            end
            if (restart) begin
                m_pulse = P; m_wait = 0; m_hold = 0; m_low = 0; m_run = 0;
                if (m_retry < 255) m_retry++;
            end
            if (set) m_lost = 1;
            else if (clr_lost) m_lost = 0;
        end
    end

    task automatic tick();
        @(negedge CLK_IN1);
        n_vec++;
        if ({mmcm_rst, sys_reset, ready, lock_lost, retry_count} !==
            {mo_mmcm, mo_sys, mo_ready, mo_lost, mo_retry}) begin
            n_bad++;
            $display("FAIL cycle t=%0t mmcm_rst/sys_reset/ready/lock_lost/retry got %b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d",
                     $time, mmcm_rst, sys_reset, ready, lock_lost, retry_count,
                     mo_mmcm, mo_sys, mo_ready, mo_lost, mo_retry);
        end
    endtask

    task automatic pin(input string nm, input int got_dut, input int got_model, input int want);
        n_vec++;
        if (got_dut != want) begin
            n_bad++;
            $display("FAIL %s t=%0t dut got %0d want %0d", nm, $time, got_dut, want);
        end
        n_vec++;
        if (got_model != want) begin
            n_bad++;
            $display("FAIL %s t=%0t model got %0d want %0d", nm, $time, got_model, want);
        end
    endtask

    task automatic pin_reset_vals(input string nm);
        pin({nm, " mmcm_rst"},  int'(mmcm_rst),  int'(mo_mmcm),  1);
        pin({nm, " sys_reset"}, int'(sys_reset), int'(mo_sys),   1);
        pin({nm, " ready"},     int'(ready),     int'(mo_ready), 0);
        pin({nm, " lock_lost"}, int'(lock_lost), int'(mo_lost),  0);
        pin({nm, " retry"},     int'(retry_count), int'(mo_retry), 0);
    endtask

    task automatic wait_mmcm_low(input int budget);
        int k = 0;
        while (mmcm_rst !== 1'b0 && k < budget) begin tick(); k++; end
        n_vec++;
        if (mmcm_rst !== 1'b0) begin
            n_bad++;
            $display("FAIL wait_mmcm_low timeout mmcm_rst got %b want 0", mmcm_rst);
        end
    endtask

    task automatic wait_ready(input int budget);
        int k = 0;
        while (ready !== 1'b1 && k < budget) begin tick(); k++; end
        n_vec++;
        if (ready !== 1'b1) begin
            n_bad++;
            $display("FAIL wait_ready timeout ready got %b want 1", ready);
        end
    endtask

    initial begin
        #1 reset = 1'b1;
        #2 pin_reset_vals("reset");
        tick();
        reset = 1'b0;

        // Lock never arrives: retry every P+LT cycles until saturation
        for (int e = 1; e <= 255 * (P + LT) + 40; e++) begin
            tick();
            if (e == 3)  pin("to pulse held", int'(mmcm_rst), int'(mo_mmcm), 1);
            if (e == 4)  pin("to pulse ends", int'(mmcm_rst), int'(mo_mmcm), 0);
            if (e == 35) pin("to retry before", int'(retry_count), int'(mo_retry), 0);
            if (e == 36) begin
                pin("to retry1", int'(retry_count), int'(mo_retry), 1);
                pin("to repulse", int'(mmcm_rst), int'(mo_mmcm), 1);
            end
            if (e == 72) pin("to retry2", int'(retry_count), int'(mo_retry), 2);
        end
        pin("retry sat", int'(retry_count), int'(mo_retry), 255);
        for (int e = 0; e < 2 * (P + LT); e++) tick();
        pin("retry no wrap", int'(retry_count), int'(mo_retry), 255);

        // Async reset between edges, then normal bring-up
        @(posedge CLK_IN1);
        #3 reset = 1'b1;
        #1 pin_reset_vals("async reset");
        tick();
        reset = 1'b0;
        for (int e = 1; e <= 25; e++) begin
            tick();
            if (e == 3)  pin("bu pulse held", int'(mmcm_rst), int'(mo_mmcm), 1);
            if (e == 4)  pin("bu pulse ends", int'(mmcm_rst), int'(mo_mmcm), 0);
            if (e == 10) locked = 1'b1;
            if (e == 20) pin("bu ready early", int'(ready), int'(mo_ready), 0);
            if (e == 21) begin
                pin("bu ready", int'(ready), int'(mo_ready), 1);
                pin("bu sys_reset", int'(sys_reset), int'(mo_sys), 0);
                pin("bu retry", int'(retry_count), int'(mo_retry), 0);
            end
        end

        // Short dropout in RUN is filtered
        locked = 1'b0;
        tick(); tick();
        locked = 1'b1;
        for (int e = 0; e < 10; e++) tick();
        pin("filter ready", int'(ready), int'(mo_ready), 1);
        pin("filter lost", int'(lock_lost), int'(mo_lost), 0);

        // Sustained dropout is a loss
        locked = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            tick();
            if (e == 4) pin("loss pending", int'(ready), int'(mo_ready), 1);
            if (e == 5) begin
                pin("loss ready", int'(ready), int'(mo_ready), 0);
                pin("loss lost", int'(lock_lost), int'(mo_lost), 1);
                pin("loss retry", int'(retry_count), int'(mo_retry), 1);
                pin("loss mmcm", int'(mmcm_rst), int'(mo_mmcm), 1);
            end
        end

        // Relock with a one-cycle glitch during qualification
        locked = 1'b1;
        wait_mmcm_low(20);
        tick(); tick(); tick();
        locked = 1'b0;
        tick();
        locked = 1'b1;
        for (int e = 1; e <= 11; e++) begin
            tick();
            if (e == 10) pin("glitch ready late", int'(ready), int'(mo_ready), 0);
            if (e == 11) begin
                pin("glitch ready", int'(ready), int'(mo_ready), 1);
                pin("glitch retry", int'(retry_count), int'(mo_retry), 1);
            end
        end

        // Clear coincident with a new loss: set wins
        locked = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            if (e == 5) clr_lost = 1'b1;
            tick();
            if (e == 4) pin("coinc pending", int'(ready), int'(mo_ready), 1);
        end
        clr_lost = 1'b0;
        pin("coinc lost", int'(lock_lost), int'(mo_lost), 1);
        pin("coinc retry", int'(retry_count), int'(mo_retry), 2);
        locked = 1'b1;
        clr_lost = 1'b1;
        tick();
        clr_lost = 1'b0;
        pin("clr lost", int'(lock_lost), int'(mo_lost), 0);
        wait_ready(60);

        // Software relock from RUN, then again mid-pulse
        force_relock = 1'b1;
        tick();
        force_relock = 1'b0;
        pin("force sys_reset", int'(sys_reset), int'(mo_sys), 1);
        pin("force mmcm", int'(mmcm_rst), int'(mo_mmcm), 1);
        pin("force lost", int'(lock_lost), int'(mo_lost), 0);
        pin("force retry", int'(retry_count), int'(mo_retry), 3);
        tick(); tick();
        force_relock = 1'b1;
        tick();
        force_relock = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick();
            if (e == 3) pin("refire held", int'(mmcm_rst), int'(mo_mmcm), 1);
            if (e == 4) pin("refire ends", int'(mmcm_rst), int'(mo_mmcm), 0);
        end
        pin("refire retry", int'(retry_count), int'(mo_retry), 4);

        // Async reset during qualification
        tick(); tick(); tick();
        @(posedge CLK_IN1);
        #3 reset = 1'b1;
        #1 pin_reset_vals("reset mid-hold");
        tick();
        reset = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick();
            if (e == 3) pin("restart held", int'(mmcm_rst), int'(mo_mmcm), 1);
            if (e == 4) pin("restart ends", int'(mmcm_rst), int'(mo_mmcm), 0);
        end
        wait_ready(40);
        pin("restart retry", int'(retry_count), int'(mo_retry), 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
